// File: rtl/usb_ahb_value_regs_p.sv
// usb_ahb_value_regs_p
//   Register and data-buffer bank behind the AHB-lite slave front end of the
//   USB endpoint. DATA accesses are streamed one byte per cycle to or from
//   the endpoint FIFO while the bus is held. The bank also keeps sticky
//   status and error flags, the self-clearing TX control and flush
//   registers, and the interrupt line.
//
// Ports
//   clk, n_rst             clock, asynchronous active-low reset
//   val_loc, hwrite_reg,   registered access location / direction / size
//   hsize_reg, state       from the AHB front end (state 1 = DATA_TRANSFER)
//   hwdata / hrdata        bus write / read data (8*BUS_BYTES bits)
//   hold                   stall request while a DATA access is streaming
//   rx_* / tx_*            packet and error information from the RX/TX sides
//   buffer_occupancy       FIFO byte count, sampled every cycle
//   rx_data, get_rx_data   FIFO pop interface (rx_data valid with the pop)
//   tx_data, store_tx_data FIFO push interface
//   tx_packet, clear       TX packet request, one-cycle FIFO flush pulse
//   d_mode, irq            TX direction indicator, interrupt
//   dbg_state              stream FSM state (0 IDLE, 1 XFER, 2 DONE)
//
// Handshake: an access is taken when state == DATA_TRANSFER. While hold is
// high the front end keeps the access (and hwdata) stable and presents no
// new access; the DONE cycle (hold low) completes a DATA access.
module usb_ahb_value_regs_p #(
  parameter int BUS_BYTES = 4,
  parameter int BUF_DEPTH = 64,
  parameter int OCC_W     = 7
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [3:0]             val_loc,
  input  logic                   hwrite_reg,
  input  logic [2:0]             hsize_reg,
  input  logic [1:0]             state,
  input  logic [8*BUS_BYTES-1:0] hwdata,
  input  logic [2:0]             rx_packet,
  input  logic                   rx_data_ready,
  input  logic                   rx_transfer_active,
  input  logic                   rx_error,
  input  logic                   tx_transfer_active,
  input  logic                   tx_error,
  input  logic [OCC_W-1:0]       buffer_occupancy,
  input  logic [7:0]             rx_data,
  output logic [8*BUS_BYTES-1:0] hrdata,
  output logic                   hold,
  output logic                   get_rx_data,
  output logic                   store_tx_data,
  output logic [7:0]             tx_data,
  output logic [1:0]             tx_packet,
  output logic                   clear,
  output logic                   d_mode,
  output logic                   irq,
  output logic [1:0]             dbg_state
);

  localparam int W      = 8 * BUS_BYTES;
  localparam int LOG_BB = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 0;
  localparam int KW     = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1;

  localparam logic [3:0] LOC_DATA   = 4'h0;
  localparam logic [3:0] LOC_STATUS = 4'h4;
  localparam logic [3:0] LOC_ERROR  = 4'h6;
  localparam logic [3:0] LOC_OCCUP  = 4'h8;
  localparam logic [3:0] LOC_TXCTL  = 4'hC;
  localparam logic [3:0] LOC_FLUSH  = 4'hD;
  localparam logic [3:0] LOC_IRQEN  = 4'hE;

  // Only bits 0 (rx err), 1 (underflow), 8 (tx err), 9 (overflow) exist.
  localparam logic [9:0] ERR_MASK = 10'h303;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } st_e;

  st_e           st_q;
  logic [KW-1:0] k_q, last_q;
  logic          wr_q;
  logic [W-1:0]  word_q;

  logic [6:0] status_q, status_d;
  logic [9:0] error_q, error_d;
  logic [7:0] tx_ctrl_q, tx_ctrl_d;
  logic [7:0] flush_q, flush_d;
  logic [7:0] irq_en_q, irq_en_d;

  logic          acc_valid, data_start, reg_wr;
  logic [2:0]    hs_eff;
  logic [KW-1:0] n_last;
  logic          xfer, rd_byte, wr_byte, occ_empty, occ_full;
  logic          underflow, overflow;
  logic [9:0]    hwdata_lo;
  logic [9:0]    err_set, err_clr;
  logic [W-1:0]  rd_val;

  // Low ten write-data bits, zero-extended for the 1-byte bus.
  if (W >= 10) begin : g_wide
    assign hwdata_lo = hwdata[9:0];
  end else begin : g_narrow
    assign hwdata_lo = {2'b00, hwdata[7:0]};
  end

  assign acc_valid  = (state == 2'd1);
  assign data_start = (st_q == S_IDLE) && acc_valid && (val_loc == LOC_DATA);
  // Register writes are never taken mid-stream.
  assign reg_wr     = acc_valid && hwrite_reg && (st_q != S_XFER);

  // Byte count N = 2^hsize clamped to the bus width; stored as N-1.
  assign hs_eff = (hsize_reg > 3'(LOG_BB)) ? 3'(LOG_BB) : hsize_reg;
  assign n_last = KW'((32'd1 << hs_eff) - 32'd1);

  assign xfer      = (st_q == S_XFER);
  assign rd_byte   = xfer && !wr_q;
  assign wr_byte   = xfer && wr_q;
  assign occ_empty = (buffer_occupancy == '0);
  assign occ_full  = (buffer_occupancy == OCC_W'(BUF_DEPTH));
  assign underflow = rd_byte && occ_empty;
  assign overflow  = wr_byte && occ_full;

  // Stream FSM: IDLE -> XFER (N cycles, one byte each) -> DONE -> IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st_q   <= S_IDLE;
      k_q    <= '0;
      last_q <= '0;
      wr_q   <= 1'b0;
      word_q <= '0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (data_start) begin
            st_q   <= S_XFER;
            k_q    <= '0;
            last_q <= n_last;
            wr_q   <= hwrite_reg;
            word_q <= '0;
          end
        end
        S_XFER: begin
          if (!wr_q) word_q[8*k_q +: 8] <= underflow ? 8'h00 : rx_data;
          if (k_q == last_q) st_q <= S_DONE;
          else               k_q  <= k_q + KW'(1);
        end
        S_DONE:  st_q <= S_IDLE;
        default: st_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    status_d    = status_q;
    status_d[5] = rx_transfer_active;
    status_d[6] = tx_transfer_active;
    // A pending DATA packet wins over the empty-FIFO clear.
    status_d[0] = (rx_data_ready && rx_packet == 3'd0) ||
                  (status_q[0] && !occ_empty);
    if (rx_data_ready) begin
      status_d[1] = (rx_packet == 3'd1);
      status_d[2] = (rx_packet == 3'd2);
      status_d[3] = (rx_packet == 3'd3);
      status_d[4] = (rx_packet == 3'd4);
    end
  end

  always_comb begin
    err_set = {overflow, tx_error, 6'b0, underflow, rx_error};
    err_clr = (reg_wr && val_loc == LOC_ERROR) ? hwdata_lo : 10'h000;
    error_d = ((error_q & ~err_clr) | err_set) & ERR_MASK;

    tx_ctrl_d = tx_ctrl_q;
    if (tx_transfer_active)                    tx_ctrl_d = 8'h00;
    else if (reg_wr && val_loc == LOC_TXCTL)   tx_ctrl_d = hwdata_lo[7:0];

    // Flush lives for exactly one cycle; that cycle drives clear.
    flush_d = 8'h00;
    if (reg_wr && val_loc == LOC_FLUSH && hwdata_lo[7:0] != 8'h00)
      flush_d = hwdata_lo[7:0];

    irq_en_d = irq_en_q;
    if (reg_wr && val_loc == LOC_IRQEN) irq_en_d = hwdata_lo[7:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      status_q  <= '0;
      error_q   <= '0;
      tx_ctrl_q <= '0;
      flush_q   <= '0;
      irq_en_q  <= '0;
    end else begin
      status_q  <= status_d;
      error_q   <= error_d;
      tx_ctrl_q <= tx_ctrl_d;
      flush_q   <= flush_d;
      irq_en_q  <= irq_en_d;
    end
  end

  always_comb begin
    rd_val = '0;
    case (val_loc)
      LOC_STATUS: rd_val = W'(status_q);
      LOC_ERROR:  rd_val = W'(error_q);
      LOC_OCCUP:  rd_val = W'(buffer_occupancy);
      LOC_TXCTL:  rd_val = W'(tx_ctrl_q);
      LOC_FLUSH:  rd_val = W'(flush_q);
      LOC_IRQEN:  rd_val = W'(irq_en_q);
      default:    rd_val = '0;
    endcase
    hrdata = '0;
    if (st_q == S_DONE && !wr_q)       hrdata = word_q;
    else if (acc_valid && !hwrite_reg) hrdata = rd_val;
  end

  assign hold          = xfer;
  assign get_rx_data   = rd_byte && !occ_empty;
  assign store_tx_data = wr_byte && !occ_full;
  assign tx_data       = wr_byte ? hwdata[8*k_q +: 8] : 8'h00;
  assign tx_packet     = tx_ctrl_q[1:0];
  assign clear         = (flush_q != 8'h00);
  assign d_mode        = tx_transfer_active;
  assign irq           = |((status_q[4:0] |
                            {1'b0, error_q[9:8], error_q[1:0]}) & irq_en_q[4:0]);
  assign dbg_state     = st_q;

endmodule

// File: tb/tb_usb_ahb_value_regs_p.sv
// Testbench for usb_ahb_value_regs_p (BUS_BYTES=4, BUF_DEPTH=64, OCC_W=7).
// Streams are checked through scoreboard queues: expected FIFO push bytes
// (txb_q) and expected DONE read words (exp_q) are queued when a stream is
// set up; src_q holds the bytes the FIFO model returns on each pop.
module tb_usb_ahb_value_regs_p;

  localparam int W = 32;

  logic         clk, n_rst;
  logic [3:0]   val_loc;
  logic         hwrite_reg;
  logic [2:0]   hsize_reg;
  logic [1:0]   state;
  logic [W-1:0] hwdata;
  logic [2:0]   rx_packet;
  logic         rx_data_ready, rx_transfer_active, rx_error;
  logic         tx_transfer_active, tx_error;
  logic [6:0]   buffer_occupancy;
  logic [7:0]   rx_data;
  logic [W-1:0] hrdata;
  logic         hold, get_rx_data, store_tx_data;
  logic [7:0]   tx_data;
  logic [1:0]   tx_packet;
  logic         clear, d_mode, irq;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   txb_q[$];
  logic [7:0]   src_q[$];

  usb_ahb_value_regs_p #(.BUS_BYTES(4), .BUF_DEPTH(64), .OCC_W(7)) dut (
    .clk(clk), .n_rst(n_rst), .val_loc(val_loc), .hwrite_reg(hwrite_reg),
    .hsize_reg(hsize_reg), .state(state), .hwdata(hwdata),
    .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
    .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
    .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
    .buffer_occupancy(buffer_occupancy), .rx_data(rx_data),
    .hrdata(hrdata), .hold(hold), .get_rx_data(get_rx_data),
    .store_tx_data(store_tx_data), .tx_data(tx_data), .tx_packet(tx_packet),
    .clear(clear), .d_mode(d_mode), .irq(irq), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic reg_write(input logic [3:0] loc, input logic [W-1:0] data);
    @(negedge clk);
    state = 2'd1; val_loc = loc; hwrite_reg = 1'b1; hwdata = data;
    @(negedge clk);
    state = 2'd0; hwrite_reg = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] loc, output logic [W-1:0] data);
    @(negedge clk);
    state = 2'd1; val_loc = loc; hwrite_reg = 1'b0;
    #1 data = hrdata;
    state = 2'd0;
  endtask

  task automatic pulse_rx(input logic [2:0] pkt);
    @(negedge clk);
    rx_packet = pkt; rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
  endtask

  // Runs one DATA access; pops the scoreboards as the DUT produces bytes
  // and the DONE word, returns the number of FIFO strobes and hold cycles.
  task automatic run_stream(input logic wr, input logic [2:0] hs,
                            input logic [W-1:0] wdata, input logic [6:0] occ,
                            output int pulses, output int holds);
    logic done;
    logic [W-1:0] ew;
    logic [7:0]   eb;
    done = 1'b0; pulses = 0; holds = 0;
    @(negedge clk);
    state = 2'd1; val_loc = 4'h0; hwrite_reg = wr; hsize_reg = hs;
    hwdata = wdata; buffer_occupancy = occ;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      state = 2'd0;
      rx_data = 8'hEE;
      if (get_rx_data) begin
        pulses++;
        rx_data = (src_q.size() > 0) ? src_q.pop_front() : 8'hEE;
      end
      if (store_tx_data) begin
        pulses++;
        eb = (txb_q.size() > 0) ? txb_q.pop_front() : 8'hXX;
        checks++;
        if (tx_data !== eb) begin
          errors++;
          $display("FAIL tx_data: got %02h expected %02h", tx_data, eb);
        end
      end
      if (hold) holds++;
      else begin
        done = 1'b1;
        if (!wr) begin
          ew = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          checks++;
          if (hrdata !== ew) begin
            errors++;
            $display("FAIL done_hrdata: got %08h expected %08h", hrdata, ew);
          end
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL stream_timeout: DONE not reached within 20 cycles");
    end
    hwrite_reg = 1'b0; rx_data = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 1'b0; state = 2'd0; val_loc = 4'h0; hwrite_reg = 1'b0;
    hsize_reg = 3'd0; hwdata = '0; rx_packet = 3'd0; rx_data_ready = 1'b0;
    rx_transfer_active = 1'b0; rx_error = 1'b0; tx_transfer_active = 1'b0;
    tx_error = 1'b0; buffer_occupancy = '0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({hrdata, hold, get_rx_data, store_tx_data, tx_data, tx_packet, clear,
         irq, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hrdata=%h hold=%b get=%b store=%b tx_data=%h tx_packet=%0d clear=%b irq=%b st=%0d expected all 0",
               hrdata, hold, get_rx_data, store_tx_data, tx_data, tx_packet,
               clear, irq, dbg_state);
    end
    tx_transfer_active = 1'b1;
    #1;
    checks++;
    if (d_mode !== 1'b1) begin
      errors++;
      $display("FAIL reset_d_mode: got %b expected 1", d_mode);
    end
    tx_transfer_active = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    int p, h;
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back(32'h44332211);
    run_stream(1'b0, 3'd2, '0, 7'd10, p, h);
    checks++;
    if (p !== 4 || h !== 4) begin
      errors++;
      $display("FAIL read_basic_counts: pops=%0d hold=%0d expected 4/4", p, h);
    end
  endtask

  task automatic test_write_basic();
    int p, h;
    txb_q = '{8'hDD, 8'hCC};
    run_stream(1'b1, 3'd1, 32'hAABBCCDD, 7'd0, p, h);
    checks++;
    if (p !== 2 || h !== 2 || txb_q.size() != 0) begin
      errors++;
      $display("FAIL write_basic_counts: pushes=%0d hold=%0d left=%0d expected 2/2/0",
               p, h, txb_q.size());
    end
  endtask

  task automatic test_underflow();
    int p, h;
    logic [W-1:0] r;
    reg_write(4'hE, 32'h02);
    exp_q.push_back(32'h0);
    run_stream(1'b0, 3'd2, '0, 7'd0, p, h);
    checks++;
    if (p !== 0 || h !== 4) begin
      errors++;
      $display("FAIL underflow_counts: pops=%0d hold=%0d expected 0/4", p, h);
    end
    reg_read(4'h6, r);
    checks++;
    if (r !== 32'h002 || irq !== 1'b1) begin
      errors++;
      $display("FAIL underflow_error: error=%h irq=%b expected 002/1", r, irq);
    end
    reg_write(4'h6, 32'h2);
    reg_read(4'h6, r);
    checks++;
    if (r !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL underflow_w1c: error=%h irq=%b expected 0/0", r, irq);
    end
  endtask

  task automatic test_overflow_errors();
    int p, h;
    logic [W-1:0] r;
    run_stream(1'b1, 3'd0, 32'h5A, 7'd64, p, h);
    checks++;
    if (p !== 0 || h !== 1) begin
      errors++;
      $display("FAIL overflow_counts: pushes=%0d hold=%0d expected 0/1", p, h);
    end
    @(negedge clk); rx_error = 1'b1;
    @(negedge clk); rx_error = 1'b0; tx_error = 1'b1;
    @(negedge clk); tx_error = 1'b0;
    reg_read(4'h6, r);
    checks++;
    if (r !== 32'h301) begin
      errors++;
      $display("FAIL error_sticky: got %h expected 301", r);
    end
    // Clear everything while a new rx_error arrives: the set must win.
    @(negedge clk);
    state = 2'd1; val_loc = 4'h6; hwrite_reg = 1'b1; hwdata = 32'h303;
    rx_error = 1'b1;
    @(negedge clk);
    state = 2'd0; hwrite_reg = 1'b0; rx_error = 1'b0;
    reg_read(4'h6, r);
    checks++;
    if (r !== 32'h001) begin
      errors++;
      $display("FAIL error_set_wins: got %h expected 001", r);
    end
    reg_write(4'h6, 32'h1);
  endtask

  task automatic test_status();
    logic [W-1:0] r;
    buffer_occupancy = 7'd5;
    pulse_rx(3'd3);
    reg_read(4'h4, r);
    checks++;
    if (r !== 32'h08) begin
      errors++;
      $display("FAIL status_ack: got %h expected 08", r);
    end
    pulse_rx(3'd4);
    reg_read(4'h4, r);
    checks++;
    if (r !== 32'h10) begin
      errors++;
      $display("FAIL status_nak: got %h expected 10", r);
    end
    pulse_rx(3'd0);
    reg_read(4'h4, r);
    checks++;
    if (r !== 32'h01) begin
      errors++;
      $display("FAIL status_data: got %h expected 01", r);
    end
    buffer_occupancy = 7'd0;
    rx_transfer_active = 1'b1;
    @(negedge clk);
    reg_read(4'h4, r);
    checks++;
    if (r !== 32'h20) begin
      errors++;
      $display("FAIL status_empty_rxact: got %h expected 20", r);
    end
    rx_transfer_active = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_control();
    logic [W-1:0] r;
    reg_write(4'hC, 32'h03);
    checks++;
    if (tx_packet !== 2'd3) begin
      errors++;
      $display("FAIL tx_packet_set: got %0d expected 3", tx_packet);
    end
    tx_transfer_active = 1'b1;
    #1;
    checks++;
    if (d_mode !== 1'b1 || tx_packet !== 2'd3) begin
      errors++;
      $display("FAIL tx_active_edge: d_mode=%b tx_packet=%0d expected 1/3",
               d_mode, tx_packet);
    end
    @(negedge clk);
    checks++;
    if (tx_packet !== 2'd0) begin
      errors++;
      $display("FAIL tx_packet_autoclear: got %0d expected 0", tx_packet);
    end
    reg_write(4'hC, 32'h02);
    reg_read(4'h4, r);
    checks++;
    if (tx_packet !== 2'd0 || r !== 32'h40) begin
      errors++;
      $display("FAIL tx_write_while_active: tx_packet=%0d status=%h expected 0/40",
               tx_packet, r);
    end
    tx_transfer_active = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush_misc();
    logic [W-1:0] r;
    reg_write(4'hD, 32'h01);
    checks++;
    if (clear !== 1'b1) begin
      errors++;
      $display("FAIL flush_pulse: clear=%b expected 1", clear);
    end
    @(negedge clk);
    checks++;
    if (clear !== 1'b0) begin
      errors++;
      $display("FAIL flush_one_cycle: clear=%b expected 0", clear);
    end
    reg_read(4'hD, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL flush_readback: got %h expected 0", r);
    end
    buffer_occupancy = 7'd37;
    reg_read(4'h8, r);
    checks++;
    if (r !== 32'd37) begin
      errors++;
      $display("FAIL occup_read: got %h expected 25", r);
    end
    reg_write(4'h3, 32'hFFFF_FFFF);
    reg_read(4'h3, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read: got %h expected 0", r);
    end
    reg_read(4'hE, r);
    checks++;
    if (r !== 32'h02) begin
      errors++;
      $display("FAIL irq_en_read: got %h expected 02", r);
    end
  endtask

  task automatic test_back_to_back();
    int p, h, n;
    logic         wr;
    logic [2:0]   hs;
    logic [W-1:0] wd, word;
    logic [6:0]   occ;
    logic [7:0]   b;
    for (int t = 0; t < 8; t++) begin
      wr  = t[0];
      hs  = 3'($urandom_range(0, 4));
      occ = 7'($urandom_range(1, 63));
      wd  = $urandom;
      n   = (hs >= 3'd2) ? 4 : (1 << hs);
      word = '0;
      for (int i = 0; i < n; i++) begin
        if (wr) txb_q.push_back(wd[8*i +: 8]);
        else begin
          b = 8'($urandom_range(0, 255));
          src_q.push_back(b);
          word = word | (W'(b) << (8 * i));
        end
      end
      if (!wr) exp_q.push_back(word);
      run_stream(wr, hs, wd, occ, p, h);
      checks++;
      if (p !== n || h !== n) begin
        errors++;
        $display("FAIL b2b_counts[%0d]: strobes=%0d hold=%0d expected %0d/%0d",
                 t, p, h, n, n);
      end
    end
    checks++;
    if (txb_q.size() != 0 || exp_q.size() != 0 || src_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_scoreboard_left: tx=%0d rd=%0d src=%0d expected 0/0/0",
               txb_q.size(), exp_q.size(), src_q.size());
    end
  endtask

  task automatic test_reset_mid_xfer();
    @(negedge clk);
    state = 2'd1; val_loc = 4'h0; hwrite_reg = 1'b0; hsize_reg = 3'd2;
    buffer_occupancy = 7'd10;
    @(negedge clk);
    state = 2'd0;
    #1;
    checks++;
    if (hold !== 1'b1 || get_rx_data !== 1'b1) begin
      errors++;
      $display("FAIL mid_xfer_started: hold=%b get=%b expected 1/1",
               hold, get_rx_data);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if (hold !== 1'b0 || get_rx_data !== 1'b0 || store_tx_data !== 1'b0 ||
        dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_xfer_reset: hold=%b get=%b store=%b st=%0d expected 0/0/0/0",
               hold, get_rx_data, store_tx_data, dbg_state);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (hold !== 1'b0 || get_rx_data !== 1'b0) begin
      errors++;
      $display("FAIL mid_xfer_no_resume: hold=%b get=%b expected 0/0",
               hold, get_rx_data);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_underflow();
    test_overflow_errors();
    test_status();
    test_tx_control();
    test_flush_misc();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_ahb_value_regs_p.md
Name: usb_ahb_value_regs_p

Overview:
- Parametrised register and data-buffer bank for the AHB-lite slave side of the USB endpoint.
- Decodes the registered access location from the AHB front end.
- Streams multi-byte buffer accesses one byte per cycle to and from the endpoint FIFO, holding the bus during streaming.
- Keeps sticky status and error flags, self-clearing TX control and flush registers, and an interrupt line.

Parameters:
BUS_BYTES, 4, hwdata/hrdata width in bytes; power of 2, 1..8
BUF_DEPTH, 64, FIFO capacity in bytes; used for full detection
OCC_W, 7, width of buffer_occupancy; must be at least clog2(BUF_DEPTH+1)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
val_loc  in  4  registered access location (map below)
hwrite_reg  in  1  registered HWRITE
hsize_reg  in  3  registered HSIZE; byte count N = 2^hsize_reg, clamped to BUS_BYTES
state  in  2  AHB front-end state; 1 = DATA_TRANSFER
hwdata  in  8*BUS_BYTES  write data
rx_packet  in  3  0 DATA, 1 IN, 2 OUT, 3 ACK, 4 NAK
rx_data_ready  in  1  packet-complete strobe from the RX side
rx_transfer_active  in  1  RX busy
rx_error  in  1  RX error strobe
tx_transfer_active  in  1  TX busy
tx_error  in  1  TX error strobe
buffer_occupancy  in  OCC_W  FIFO byte count
rx_data  in  8  FIFO read byte; valid in the same cycle as get_rx_data
hrdata  out  8*BUS_BYTES  read data
hold  out  1  stall request to the AHB front end
get_rx_data  out  1  FIFO pop strobe
store_tx_data  out  1  FIFO push strobe
tx_data  out  8  byte to push
tx_packet  out  2  0 none, 1 DATA, 2 ACK, 3 NAK
clear  out  1  one-cycle FIFO flush pulse
d_mode  out  1  equals tx_transfer_active
irq  out  1  OR of (status[4:0] | {error[9:8], error[1:0]}) AND irq_en

Behaviour:
- Reset values:
  - all registers 0 and the stream FSM in IDLE;
  - every output 0 except d_mode, which follows its input.
- An access is valid when state == DATA_TRANSFER.
- Location map:
  - 0 DATA;
  - 4 STATUS (read-only);
  - 6 ERROR (write-1-to-clear);
  - 8 OCCUP (read-only);
  - C TX_CONTROL;
  - D FLUSH;
  - E IRQ_EN (8-bit);
  - any other location reads 0 and ignores writes.
- Reads of non-DATA locations are combinational and zero-extended to the bus width.
- Stream FSM: IDLE, XFER, DONE.
  - IDLE -> XFER on a valid DATA access; byte index k resets to 0 and N is latched.
  - XFER: hold = 1.
    - Write: store_tx_data = 1 and tx_data = hwdata[8k+7:8k].
    - Read: get_rx_data = 1 and rx_data is captured into word byte k (little-endian).
    - k increments every cycle; after byte N-1 the FSM moves to DONE.
  - DONE: one cycle with hold = 0.
    - A DATA read drives hrdata with the assembled word, zero-extended above byte N-1.
    - The FSM then returns to IDLE.
  - Latency: N+1 cycles from the access until the DONE cycle.
- Underflow: a read byte taken while buffer_occupancy == 0 suppresses get_rx_data, captures 0x00 and sets error[1].
- Overflow: a write byte taken while buffer_occupancy == BUF_DEPTH suppresses store_tx_data and sets error[9].
- Occupancy is sampled each cycle; no internal prediction.
- STATUS bits:
  - bit0 rx-data-available: set on rx_data_ready with rx_packet == DATA; cleared when occupancy == 0 and no set is pending.
  - bits1..4 (IN, OUT, ACK, NAK): set on rx_data_ready with the matching packet type; cleared on rx_data_ready with any other type.
  - bit5 = rx_transfer_active, bit6 = tx_transfer_active, both registered.
- ERROR bits:
  - bit0 set on rx_error, bit8 set on tx_error.
  - All error bits are sticky until written 1 at location 6.
  - A set and a clear in the same cycle: set wins.
- TX_CONTROL:
  - A write loads hwdata[7:0].
  - tx_packet = tx_control[1:0] while nonzero.
  - The register clears on the first cycle tx_transfer_active is observed high.
  - A write while TX is active is ignored.
- FLUSH:
  - A nonzero write sets the register; the next cycle clear = 1 and the register returns to 0.
  - A FLUSH write during XFER is ignored.
- A new access arriving while hold = 1 is not accepted (the front end stalls).
- Reset asserted mid-XFER aborts immediately: no strobes, the FSM returns to IDLE.

Test Plan:
- BUS_BYTES=4, occupancy=10, 4-byte read at loc 0, rx_data 0x11,0x22,0x33,0x44 -> 4 get_rx_data pulses, hold high 4 cycles, DONE hrdata=0x44332211.
- 2-byte write hwdata=0xAABBCCDD, occupancy=0 -> store_tx_data twice, tx_data 0xDD then 0xCC, hold high 2 cycles.
- 4-byte read with occupancy=0 -> no get_rx_data, hrdata=0, error[1]=1, irq=1 when irq_en[1]=1; writing 0x2 to loc 6 clears it.
- rx_data_ready with rx_packet=ACK, then with NAK -> status[3]=1, then status[3]=0 and status[4]=1.
- Write 0x03 to TX_CONTROL -> tx_packet=3; raise tx_transfer_active -> tx_packet=0 next cycle, d_mode=1.
- Write 0x01 to FLUSH -> clear=1 for exactly one cycle; read FLUSH afterwards returns 0. Assert n_rst during XFER -> hold and strobes drop immediately.
